// File: rtl/axis_width_conv.sv
// AXI-Stream byte-width converter (IN_BYTES -> OUT_BYTES) built on a byte-granular shift buffer.
// Optional feature: define AXIS_GEN_LAST_EN to generate tlast from a byte counter and max_byte_len.
module axis_width_conv #(
  parameter int IN_BYTES  = 6,
  parameter int OUT_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
`ifdef AXIS_GEN_LAST_EN
  input  logic [31:0]            max_byte_len,
`endif
  input  logic                   rx_axis_vld,
  input  logic [8*IN_BYTES-1:0]  rx_axis_data,
  input  logic [IN_BYTES-1:0]    rx_axis_strb,
  input  logic                   rx_axis_last,
  output logic                   rx_axis_rdy,
  output logic                   tx_axis_vld,
  output logic [8*OUT_BYTES-1:0] tx_axis_data,
  output logic [OUT_BYTES-1:0]   tx_axis_strb,
  output logic                   tx_axis_last,
  input  logic                   tx_axis_rdy,
  output logic                   err_strb
);

  localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
  localparam int CW        = $clog2(BUF_BYTES + 1);

  logic [7:0]    byte_buf_q [BUF_BYTES];
  logic [7:0]    byte_buf_d [BUF_BYTES];
  logic [CW-1:0] count_q, count_d;
  logic          last_pend_q, last_pend_d;
  logic          err_q, err_d;
  logic          active_q;

  logic push, pop, beat_last;
  int   cnt_i, pop_n, push_n, strb_n, base_i;

`ifdef AXIS_GEN_LAST_EN
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] gen_len, gen_sum;
  logic        gen_unused_last;

  assign gen_unused_last = rx_axis_last;
`endif

  always_comb begin
    cnt_i       = int'(count_q);
    rx_axis_rdy = active_q & enable & ~last_pend_q & (cnt_i <= BUF_BYTES - IN_BYTES);
    tx_axis_vld = (cnt_i >= OUT_BYTES) | last_pend_q;
    tx_axis_last = last_pend_q & (cnt_i <= OUT_BYTES);
    push = rx_axis_vld & rx_axis_rdy;
    pop  = tx_axis_vld & tx_axis_rdy;
    pop_n = pop ? ((cnt_i < OUT_BYTES) ? cnt_i : OUT_BYTES) : 0;

    strb_n = 0;
    for (int j = 0; j < IN_BYTES; j++) strb_n += int'(rx_axis_strb[j]);

`ifdef AXIS_GEN_LAST_EN
    // The frame length is latched on the first beat of each frame.
    gen_len    = (byte_cnt_q == 32'd0) ? max_byte_len : len_q;
    gen_sum    = byte_cnt_q + 32'(strb_n);
    beat_last  = (gen_sum >= gen_len);
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    if (push) begin
      byte_cnt_d = beat_last ? 32'd0 : gen_sum;
      len_d      = gen_len;
    end
`else
    beat_last = rx_axis_last;
`endif

    // A short non-last beat is flagged and still consumed as a full beat.
    err_d  = err_q;
    push_n = 0;
    if (push) begin
      if (!beat_last && !(&rx_axis_strb)) begin
        err_d  = 1'b1;
        push_n = (strb_n == 0) ? 0 : IN_BYTES;
      end else begin
        push_n = strb_n;
      end
    end

    base_i = cnt_i - pop_n;
    for (int i = 0; i < BUF_BYTES; i++) begin
      byte_buf_d[i] = 8'h00;
      for (int j = 0; j < BUF_BYTES; j++)
        if (j == i + pop_n) byte_buf_d[i] = byte_buf_q[j];
      for (int j = 0; j < IN_BYTES; j++)
        if ((i == base_i + j) && (j < push_n)) byte_buf_d[i] = rx_axis_data[8*j +: 8];
    end
    count_d = CW'(base_i + push_n);

    last_pend_d = last_pend_q;
    if (pop && tx_axis_last)   last_pend_d = 1'b0;
    else if (push && beat_last) last_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_BYTES; i++) byte_buf_q[i] <= 8'h00;
      count_q     <= '0;
      last_pend_q <= 1'b0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
`ifdef AXIS_GEN_LAST_EN
      byte_cnt_q  <= 32'd0;
      len_q       <= 32'd0;
`endif
    end else begin
      for (int i = 0; i < BUF_BYTES; i++) byte_buf_q[i] <= byte_buf_d[i];
      count_q     <= count_d;
      last_pend_q <= last_pend_d;
      err_q       <= err_d;
      active_q    <= 1'b1;
`ifdef AXIS_GEN_LAST_EN
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
`endif
    end
  end

  // Bytes above count are kept zero in the buffer, so output data needs no masking.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_BYTES; gi++) begin : g_tx
      assign tx_axis_data[8*gi +: 8] = byte_buf_q[gi];
      assign tx_axis_strb[gi]        = (int'(count_q) > gi);
    end
  endgenerate

  assign err_strb = err_q;

endmodule

// File: tb/tb_axis_width_conv.sv
// Scoreboard bench for axis_width_conv: a 6->4 instance with a byte-queue model and a 4->6 instance.
`timescale 1ns/1ps
module tb_axis_width_conv;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable;
  logic [31:0] max_byte_len;

  logic        a_rx_vld, a_rx_last, a_rx_rdy, a_tx_vld, a_tx_last, a_tx_rdy, a_err;
  logic [47:0] a_rx_data;
  logic [5:0]  a_rx_strb;
  logic [31:0] a_tx_data;
  logic [3:0]  a_tx_strb;

  logic        b_rx_vld, b_rx_last, b_rx_rdy, b_tx_vld, b_tx_last, b_tx_rdy, b_err;
  logic [31:0] b_rx_data;
  logic [3:0]  b_rx_strb;
  logic [47:0] b_tx_data;
  logic [5:0]  b_tx_strb;

  axis_width_conv #(.IN_BYTES(6), .OUT_BYTES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef AXIS_GEN_LAST_EN
    .max_byte_len(max_byte_len),
`endif
    .rx_axis_vld(a_rx_vld), .rx_axis_data(a_rx_data), .rx_axis_strb(a_rx_strb),
    .rx_axis_last(a_rx_last), .rx_axis_rdy(a_rx_rdy),
    .tx_axis_vld(a_tx_vld), .tx_axis_data(a_tx_data), .tx_axis_strb(a_tx_strb),
    .tx_axis_last(a_tx_last), .tx_axis_rdy(a_tx_rdy), .err_strb(a_err)
  );

  axis_width_conv #(.IN_BYTES(4), .OUT_BYTES(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef AXIS_GEN_LAST_EN
    .max_byte_len(max_byte_len),
`endif
    .rx_axis_vld(b_rx_vld), .rx_axis_data(b_rx_data), .rx_axis_strb(b_rx_strb),
    .rx_axis_last(b_rx_last), .rx_axis_rdy(b_rx_rdy),
    .tx_axis_vld(b_tx_vld), .tx_axis_data(b_tx_data), .tx_axis_strb(b_tx_strb),
    .tx_axis_last(b_tx_last), .tx_axis_rdy(b_tx_rdy), .err_strb(b_err)
  );

  int checks = 0;
  int errors = 0;
  beat_t qa[$];
  beat_t qb[$];
  logic [7:0] mbytes[$];
  logic [7:0] seed = 8'h01;
  int a_beats = 0, a_lasts = 0;
  logic [3:0] a_last_strb = 4'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected-beat model for the 6->4 instance: bytes in stream order, cut into 4-byte beats.
  task automatic emit_a(input int take, input logic last);
    beat_t bt;
    bt.data = 64'h0;
    for (int i = 0; i < take; i++) bt.data[8*i +: 8] = mbytes.pop_front();
    bt.strb = 8'((1 << take) - 1);
    bt.last = last;
    qa.push_back(bt);
  endtask

  task automatic model_push(input logic [47:0] d, input logic [5:0] s, input logic last);
    int n;
    n = $countones(s);
    if (!last && s != 6'h3F && s != 6'h00) n = 6;
    for (int i = 0; i < n; i++) mbytes.push_back(d[8*i +: 8]);
    if (!last) begin
      while (mbytes.size() >= 4) emit_a(4, 1'b0);
    end else if (mbytes.size() == 0) begin
      emit_a(0, 1'b1);
    end else begin
      while (mbytes.size() > 0) begin
        if (mbytes.size() > 4) emit_a(4, 1'b0);
        else emit_a(mbytes.size(), 1'b1);
      end
    end
  endtask

  task automatic make_data(output logic [47:0] d);
    for (int i = 0; i < 6; i++) begin
      d[8*i +: 8] = seed;
      seed = seed + 8'h01;
    end
  endtask

  task automatic send_a(input logic [47:0] d, input logic [5:0] s, input logic dut_last,
                        input logic model_last);
    int t;
    a_rx_data = d; a_rx_strb = s; a_rx_last = dut_last; a_rx_vld = 1'b1;
    t = 0;
    @(negedge clk);
    while (!a_rx_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!a_rx_rdy) begin
      checks++; errors++;
      $display("FAIL rx_a_timeout: got rdy=0 expected rdy=1");
    end
    @(posedge clk);
    #1;
    a_rx_vld = 1'b0;
    model_push(d, s, model_last);
  endtask

  task automatic send_frame_a(input int nb, input logic [5:0] last_strb);
    logic [47:0] d;
    for (int b = 0; b < nb; b++) begin
      make_data(d);
      send_a(d, (b == nb - 1) ? last_strb : 6'h3F, b == nb - 1, b == nb - 1);
    end
  endtask

  task automatic send_b(input logic [31:0] d, input logic last);
    int t;
    b_rx_data = d; b_rx_strb = 4'hF; b_rx_last = last; b_rx_vld = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_rx_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!b_rx_rdy) begin
      checks++; errors++;
      $display("FAIL rx_b_timeout: got rdy=0 expected rdy=1");
    end
    @(posedge clk);
    #1;
    b_rx_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 64'(qa.size() + qb.size()), 64'd0);
  endtask

  // Scoreboard monitors: compare whenever a beat is presented and accepted.
  always @(negedge clk) begin
    if (rst_n && a_tx_vld && a_tx_rdy) begin
      beat_t bt;
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got beat %0h expected none", a_tx_data);
      end else begin
        bt = qa.pop_front();
        check("a_data", 64'(a_tx_data), bt.data);
        check("a_strb", 64'(a_tx_strb), 64'(bt.strb));
        check("a_last", 64'(a_tx_last), 64'(bt.last));
      end
      a_beats++;
      if (a_tx_last) begin
        a_lasts++;
        a_last_strb = a_tx_strb;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_tx_vld && b_tx_rdy) begin
      beat_t bt;
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got beat %0h expected none", b_tx_data);
      end else begin
        bt = qb.pop_front();
        check("b_data", 64'(b_tx_data), bt.data);
        check("b_strb", 64'(b_tx_strb), 64'(bt.strb));
        check("b_last", 64'(b_tx_last), 64'(bt.last));
      end
    end
  end

  // Output must hold steady while stalled.
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_s;
  logic        hold_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_vld", 64'(a_tx_vld), 64'd1);
        check("stall_data", 64'(a_tx_data), 64'(hold_d));
        check("stall_strb", 64'(a_tx_strb), 64'(hold_s));
        check("stall_last", 64'(a_tx_last), 64'(hold_l));
      end
      hold_v = a_tx_vld && !a_tx_rdy;
      hold_d = a_tx_data; hold_s = a_tx_strb; hold_l = a_tx_last;
    end
  end

  initial begin
    int b0, l0;
    beat_t bt;
    logic [47:0] d;
    rst_n = 1'b0; enable = 1'b1; max_byte_len = 32'd24;
    a_rx_vld = 1'b0; a_rx_data = '0; a_rx_strb = '0; a_rx_last = 1'b0; a_tx_rdy = 1'b1;
    b_rx_vld = 1'b0; b_rx_data = '0; b_rx_strb = '0; b_rx_last = 1'b0; b_tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_tx_vld", 64'(a_tx_vld), 64'd0);
    check("rst_a_rx_rdy", 64'(a_rx_rdy), 64'd0);
    check("rst_a_tx_data", 64'(a_tx_data), 64'd0);
    check("rst_a_tx_strb", 64'(a_tx_strb), 64'd0);
    check("rst_a_tx_last", 64'(a_tx_last), 64'd0);
    check("rst_a_err", 64'(a_err), 64'd0);
    check("rst_b_tx_vld", 64'(b_tx_vld), 64'd0);
    check("rst_b_rx_rdy", 64'(b_rx_rdy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef AXIS_GEN_LAST_EN
    // 3 frames of 24 bytes, rx_last never driven: tx_last on every 6th beat.
    b0 = a_beats; l0 = a_lasts;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        make_data(d);
        send_a(d, 6'h3F, 1'b0, b == 3);
      end
    end
    wait_drain("t5_drain");
    check("t5_beats", 64'(a_beats - b0), 64'd18);
    check("t5_lasts", 64'(a_lasts - l0), 64'd3);
`else
    // 4 full beats -> 6 full output beats, one last.
    b0 = a_beats; l0 = a_lasts;
    send_frame_a(4, 6'h3F);
    wait_drain("t1_drain");
    check("t1_beats", 64'(a_beats - b0), 64'd6);
    check("t1_lasts", 64'(a_lasts - l0), 64'd1);
    check("t1_last_strb", 64'(a_last_strb), 64'hF);

    // 18 bytes -> 5 beats, final one carries 2 bytes.
    b0 = a_beats;
    send_frame_a(3, 6'h3F);
    wait_drain("t2_drain");
    check("t2_beats", 64'(a_beats - b0), 64'd5);
    check("t2_last_strb", 64'(a_last_strb), 64'h3);

    // Backpressure for 5 cycles mid-frame.
    fork
      send_frame_a(4, 6'h3F);
      begin
        repeat (3) @(posedge clk);
        #1 a_tx_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t3_rx_rdy_low", 64'(a_rx_rdy), 64'd0);
        a_tx_rdy = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // enable low stops input acceptance.
    enable = 1'b0;
    @(negedge clk);
    check("en_low_rdy", 64'(a_rx_rdy), 64'd0);
    @(posedge clk);
    #1 enable = 1'b1;

    // Short non-last beat: sticky error, beat consumed as 6 bytes.
    make_data(d);
    send_a(d, 6'h0F, 1'b0, 1'b0);
    make_data(d);
    send_a(d, 6'h3F, 1'b1, 1'b1);
    wait_drain("t6_drain");
    check("t6_err_set", 64'(a_err), 64'd1);
    send_frame_a(2, 6'h3F);
    wait_drain("t6_drain2");
    check("t6_err_sticky", 64'(a_err), 64'd1);

    // Reset with data buffered.
    a_tx_rdy = 1'b0;
    make_data(d);
    send_a(d, 6'h3F, 1'b0, 1'b0);
    check("t4_pre_vld", 64'(a_tx_vld), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_tx_vld", 64'(a_tx_vld), 64'd0);
    check("t4_rx_rdy", 64'(a_rx_rdy), 64'd0);
    check("t4_tx_strb", 64'(a_tx_strb), 64'd0);
    check("t4_err", 64'(a_err), 64'd0);
    qa.delete();
    mbytes.delete();
    rst_n = 1'b1; a_tx_rdy = 1'b1;
    @(posedge clk);
    #1;
    b0 = a_beats;
    send_frame_a(2, 6'h07);
    wait_drain("t4_drain");
    check("t4_beats", 64'(a_beats - b0), 64'd3);
    check("t4_last_strb", 64'(a_last_strb), 64'h1);

    // Empty last beat on an empty buffer -> one beat, strb 0, last 1.
    b0 = a_beats;
    send_a(48'h0, 6'h00, 1'b1, 1'b1);
    wait_drain("empty_drain");
    check("empty_beats", 64'(a_beats - b0), 64'd1);
    check("empty_strb", 64'(a_last_strb), 64'h0);

    // 4->6: three 4-byte beats -> two 6-byte beats, last on the second.
    send_b(32'hA3A2A1A0, 1'b0);
    send_b(32'hA7A6A5A4, 1'b0);
    bt.data = 64'h0000_A5A4A3A2A1A0; bt.strb = 8'h3F; bt.last = 1'b0;
    qb.push_back(bt);
    send_b(32'hABAAA9A8, 1'b1);
    bt.data = 64'h0000_ABAAA9A8A7A6; bt.strb = 8'h3F; bt.last = 1'b1;
    qb.push_back(bt);
    wait_drain("t6b_drain");
    check("t6b_err", 64'(b_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
